// File: rtl/basis_meas_if.sv
// Handshake and data bundle between the calibration FSM / plant side and
// basis_meas_sequencer. The slave modport is the sequencer's view and the
// master modport is the controller/plant view.
interface basis_meas_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADC_WIDTH  = 12
);
  logic                         start;
  logic                         abort;
  logic                         busy;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] x0_out;
  logic signed [DATA_WIDTH-1:0] x1_out;
  logic [1:0]                   plant_mode;
  logic                         adc_valid;
  logic [ADC_WIDTH-1:0]         adc_ch0;
  logic [ADC_WIDTH-1:0]         adc_ch1;
  logic [ADC_WIDTH-1:0]         m_r0c0;
  logic [ADC_WIDTH-1:0]         m_r1c0;
  logic [ADC_WIDTH-1:0]         m_r0c1;
  logic [ADC_WIDTH-1:0]         m_r1c1;
  logic                         sat_flag;
  logic                         err_timeout;

  modport master (
    output start, abort, adc_valid, adc_ch0, adc_ch1,
    input  busy, done, x0_out, x1_out, plant_mode,
    input  m_r0c0, m_r1c0, m_r0c1, m_r1c1, sat_flag, err_timeout
  );

  modport slave (
    input  start, abort, adc_valid, adc_ch0, adc_ch1,
    output busy, done, x0_out, x1_out, plant_mode,
    output m_r0c0, m_r1c0, m_r0c1, m_r1c1, sat_flag, err_timeout
  );
endinterface

// File: rtl/basis_meas_sequencer.sv
// Two-basis column measurement sequencer. Applies x=[1,0] then x=[0,1],
// waits SETTLE_CYCLES after each apply, averages AVG_SAMPLES ADC samples per
// channel and publishes the four averaged column magnitudes with a done pulse.
// Optional feature macro: MEAS_TIMEOUT_EN (sample timeout -> err_timeout pulse
// and return to IDLE). Without it SAMPLE waits indefinitely.
module basis_meas_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADC_WIDTH      = 12,
  parameter int SETTLE_CYCLES  = 16,
  parameter int AVG_SAMPLES    = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic         clk,
  input logic         rst,
  basis_meas_if.slave bus
);
  localparam int LOG2_AVG = (AVG_SAMPLES > 1) ? $clog2(AVG_SAMPLES) : 0;
  localparam int ACC_W    = ADC_WIDTH + LOG2_AVG;
  localparam int SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SMP_W    = (AVG_SAMPLES > 1) ? $clog2(AVG_SAMPLES) : 1;
  localparam logic [ADC_WIDTH-1:0] ADC_MAX = '1;
  localparam logic signed [DATA_WIDTH-1:0] X_ONE = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  // Average of a full accumulator: divide by the power-of-two sample count, truncating.
  function automatic logic [ADC_WIDTH-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] sh;
    sh = acc >> LOG2_AVG;
    return sh[ADC_WIDTH-1:0];
  endfunction

  state_t                       state_q, state_nxt;
  logic                         basis_q, basis_nxt;
  logic [SET_W-1:0]             set_cnt_q, set_cnt_nxt;
  logic [SMP_W-1:0]             smp_cnt_q, smp_cnt_nxt;
  logic [ACC_W-1:0]             acc0_q, acc0_nxt, acc1_q, acc1_nxt, sum0, sum1;
  logic [ADC_WIDTH-1:0]         m00_q, m10_q, m01_q, m11_q;
  logic [ADC_WIDTH-1:0]         m00_nxt, m10_nxt, m01_nxt, m11_nxt;
  logic                         sat_q, sat_nxt;
  logic                         busy_q, busy_nxt, done_q, done_nxt;
  logic signed [DATA_WIDTH-1:0] x0_q, x0_nxt, x1_q, x1_nxt;
  logic [1:0]                   mode_q, mode_nxt;
  logic                         active_nxt;
`ifdef MEAS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]              tcnt_q, tcnt_nxt;
  logic                         err_q, err_nxt;
`endif

  assign sum0 = acc0_q + ACC_W'(bus.adc_ch0);
  assign sum1 = acc1_q + ACC_W'(bus.adc_ch1);

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_nxt   = state_q;
    basis_nxt   = basis_q;
    set_cnt_nxt = set_cnt_q;
    smp_cnt_nxt = smp_cnt_q;
    acc0_nxt    = acc0_q;
    acc1_nxt    = acc1_q;
    m00_nxt     = m00_q;
    m10_nxt     = m10_q;
    m01_nxt     = m01_q;
    m11_nxt     = m11_q;
    sat_nxt     = sat_q;
`ifdef MEAS_TIMEOUT_EN
    tcnt_nxt    = tcnt_q;
    err_nxt     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = S_APPLY;
          basis_nxt = 1'b0;
          sat_nxt   = 1'b0;
          acc0_nxt  = '0;
          acc1_nxt  = '0;
        end
      end
      S_APPLY: begin
        set_cnt_nxt = '0;
        state_nxt   = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt   = S_SAMPLE;
          smp_cnt_nxt = '0;
`ifdef MEAS_TIMEOUT_EN
          tcnt_nxt    = '0;
`endif
        end else begin
          set_cnt_nxt = set_cnt_q + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        if (bus.adc_valid) begin
          if (bus.adc_ch0 == ADC_MAX || bus.adc_ch1 == ADC_MAX) sat_nxt = 1'b1;
`ifdef MEAS_TIMEOUT_EN
          tcnt_nxt = '0;
`endif
          if (smp_cnt_q == SMP_W'(AVG_SAMPLES - 1)) begin
            if (!basis_q) begin
              m00_nxt   = avg_trunc(sum0);
              m10_nxt   = avg_trunc(sum1);
              basis_nxt = 1'b1;
              state_nxt = S_APPLY;
            end else begin
              m01_nxt   = avg_trunc(sum0);
              m11_nxt   = avg_trunc(sum1);
              state_nxt = S_DONE;
            end
            acc0_nxt    = '0;
            acc1_nxt    = '0;
            smp_cnt_nxt = '0;
          end else begin
            acc0_nxt    = sum0;
            acc1_nxt    = sum1;
            smp_cnt_nxt = smp_cnt_q + SMP_W'(1);
          end
        end
`ifdef MEAS_TIMEOUT_EN
        else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
          acc0_nxt  = '0;
          acc1_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt_q + TO_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort cancels the run outright, including a sample landing the same cycle
    if (bus.abort && state_q != S_IDLE) begin
      state_nxt   = S_IDLE;
      acc0_nxt    = '0;
      acc1_nxt    = '0;
      set_cnt_nxt = '0;
      smp_cnt_nxt = '0;
      m00_nxt     = m00_q;
      m10_nxt     = m10_q;
      m01_nxt     = m01_q;
      m11_nxt     = m11_q;
      sat_nxt     = sat_q;
`ifdef MEAS_TIMEOUT_EN
      err_nxt     = 1'b0;
      tcnt_nxt    = '0;
`endif
    end
    active_nxt = (state_nxt == S_APPLY) || (state_nxt == S_SETTLE) ||
                 (state_nxt == S_SAMPLE);
    busy_nxt   = (state_nxt != S_IDLE);
    done_nxt   = (state_nxt == S_DONE);
    x0_nxt     = (active_nxt && !basis_nxt) ? X_ONE : '0;
    x1_nxt     = (active_nxt && basis_nxt) ? X_ONE : '0;
    mode_nxt   = active_nxt ? 2'd1 : 2'd0;
  end

  // State, datapath and output registers; async reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      basis_q   <= 1'b0;
      set_cnt_q <= '0;
      smp_cnt_q <= '0;
      acc0_q    <= '0;
      acc1_q    <= '0;
      m00_q     <= '0;
      m10_q     <= '0;
      m01_q     <= '0;
      m11_q     <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      mode_q    <= 2'd0;
`ifdef MEAS_TIMEOUT_EN
      tcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      basis_q   <= basis_nxt;
      set_cnt_q <= set_cnt_nxt;
      smp_cnt_q <= smp_cnt_nxt;
      acc0_q    <= acc0_nxt;
      acc1_q    <= acc1_nxt;
      m00_q     <= m00_nxt;
      m10_q     <= m10_nxt;
      m01_q     <= m01_nxt;
      m11_q     <= m11_nxt;
      sat_q     <= sat_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      x0_q      <= x0_nxt;
      x1_q      <= x1_nxt;
      mode_q    <= mode_nxt;
`ifdef MEAS_TIMEOUT_EN
      tcnt_q    <= tcnt_nxt;
      err_q     <= err_nxt;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.x0_out     = x0_q;
  assign bus.x1_out     = x1_q;
  assign bus.plant_mode = mode_q;
  assign bus.m_r0c0     = m00_q;
  assign bus.m_r1c0     = m10_q;
  assign bus.m_r0c1     = m01_q;
  assign bus.m_r1c1     = m11_q;
  assign bus.sat_flag   = sat_q;
`ifdef MEAS_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_basis_meas_sequencer.sv
// Directed testbench for basis_meas_sequencer at default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_basis_meas_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  basis_meas_if #(.DATA_WIDTH(16), .ADC_WIDTH(12)) bus ();

  basis_meas_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle plant/ADC stimulus; n counts cycles after the start cycle (n=0)
  task automatic drive_adc(input int mode, input int n);
    bus.adc_valid = 1'b1;
    case (mode)
      0: begin
        bus.adc_ch0 = (n < 26) ? 12'd100 : 12'd300;
        bus.adc_ch1 = (n < 26) ? 12'd200 : 12'd50;
      end
      1: begin
        bus.adc_valid = ((n % 2) == 0);
        if (n < 33) begin
          bus.adc_ch0 = (n >= 18) ? 12'((n - 18) / 2) : 12'd0;
          bus.adc_ch1 = 12'd40;
        end else begin
          bus.adc_ch0 = 12'd17;
          bus.adc_ch1 = 12'd1000;
        end
      end
      2: begin
        bus.adc_ch0 = (n < 26) ? 12'd100 : 12'd300;
        bus.adc_ch1 = (n < 26) ? 12'd200 : ((n == 45) ? 12'hFFF : 12'd50);
      end
      3: begin
        bus.adc_ch0 = (n < 26) ? 12'd500 : 12'd300;
        bus.adc_ch1 = (n < 26) ? 12'd600 : 12'd50;
      end
      default: begin
        bus.adc_valid = 1'b0;
        bus.adc_ch0   = 12'd0;
        bus.adc_ch1   = 12'd0;
      end
    endcase
  endtask

  // Issues a start, then runs max_n cycles driving stimulus and recording events
  task automatic meas_run(input int mode, input int abort_at, input int extra_start_at,
                          input int snap_at, input int max_n,
                          output int done_at, output int done_cnt, output int err_at,
                          output int err_cnt, output logic snap_busy,
                          output logic [15:0] snap_x0, output logic [15:0] snap_x1,
                          output logic [1:0] snap_mode, output logic snap_sat);
    done_at = -1; done_cnt = 0; err_at = -1; err_cnt = 0;
    snap_busy = 1'bx; snap_x0 = 'x; snap_x1 = 'x; snap_mode = 'x; snap_sat = 1'bx;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    drive_adc(mode, 0);
    for (int n = 1; n <= max_n; n++) begin
      tick();
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (bus.err_timeout === 1'b1) begin
        err_cnt++;
        if (err_at < 0) err_at = n;
      end
      if (n == snap_at) begin
        snap_busy = bus.busy; snap_x0 = bus.x0_out; snap_x1 = bus.x1_out;
        snap_mode = bus.plant_mode; snap_sat = bus.sat_flag;
      end
      bus.start = (n == extra_start_at);
      bus.abort = (n == abort_at);
      drive_adc(mode, n);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.x0_out !== 16'sd0 || bus.x1_out !== 16'sd0) begin errors++; $display("FAIL reset_x got %h/%h want 0/0", bus.x0_out, bus.x1_out); end
    checks++; if (bus.plant_mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", bus.plant_mode); end
    checks++; if ({bus.m_r0c0, bus.m_r1c0, bus.m_r0c1, bus.m_r1c1} !== 48'd0) begin errors++; $display("FAIL reset_m got %h want 0", {bus.m_r0c0, bus.m_r1c0, bus.m_r0c1, bus.m_r1c1}); end
    checks++; if (bus.sat_flag !== 1'b0 || bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", bus.sat_flag, bus.err_timeout); end
  endtask

  task automatic test_basic();
    int da, dc, ea, ec; logic sb, ss; logic [15:0] sx0, sx1; logic [1:0] sm;
    meas_run(0, -1, -1, 1, 55, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (sb !== 1'b1 || sx0 !== 16'h7FFF || sx1 !== 16'h0000 || sm !== 2'd1) begin errors++; $display("FAIL basic_apply got busy=%b x0=%h x1=%h mode=%0d want 1 7fff 0000 1", sb, sx0, sx1, sm); end
    checks++; if (da !== 51) begin errors++; $display("FAIL basic_latency got %0d want 51", da); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", dc); end
    checks++; if (bus.m_r0c0 !== 12'd100 || bus.m_r1c0 !== 12'd200) begin errors++; $display("FAIL basic_col0 got %0d/%0d want 100/200", bus.m_r0c0, bus.m_r1c0); end
    checks++; if (bus.m_r0c1 !== 12'd300 || bus.m_r1c1 !== 12'd50) begin errors++; $display("FAIL basic_col1 got %0d/%0d want 300/50", bus.m_r0c1, bus.m_r1c1); end
    checks++; if (bus.sat_flag !== 1'b0 || bus.busy !== 1'b0 || bus.x0_out !== 16'sd0 || bus.plant_mode !== 2'd0) begin errors++; $display("FAIL basic_idle got sat=%b busy=%b x0=%h mode=%0d want 0 0 0 0", bus.sat_flag, bus.busy, bus.x0_out, bus.plant_mode); end
  endtask

  task automatic test_avg_toggle();
    int da, dc, ea, ec; logic sb, ss; logic [15:0] sx0, sx1; logic [1:0] sm;
    meas_run(1, -1, -1, 40, 70, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (sx0 !== 16'h0000 || sx1 !== 16'h7FFF) begin errors++; $display("FAIL toggle_basis1_x got %h/%h want 0000/7fff", sx0, sx1); end
    checks++; if (da !== 65) begin errors++; $display("FAIL toggle_latency got %0d want 65", da); end
    checks++; if (bus.m_r0c0 !== 12'd3 || bus.m_r1c0 !== 12'd40) begin errors++; $display("FAIL toggle_col0 got %0d/%0d want 3/40", bus.m_r0c0, bus.m_r1c0); end
    checks++; if (bus.m_r0c1 !== 12'd17 || bus.m_r1c1 !== 12'd1000) begin errors++; $display("FAIL toggle_col1 got %0d/%0d want 17/1000", bus.m_r0c1, bus.m_r1c1); end
  endtask

  task automatic test_saturation();
    int da, dc, ea, ec; logic sb, ss; logic [15:0] sx0, sx1; logic [1:0] sm;
    meas_run(2, -1, -1, 50, 55, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (ss !== 1'b1) begin errors++; $display("FAIL sat_in_run got %b want 1", ss); end
    checks++; if (da !== 51 || bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_after_done got done_at=%0d sat=%b want 51 1", da, bus.sat_flag); end
    checks++; if (bus.m_r1c1 !== 12'd555) begin errors++; $display("FAIL sat_avg got %0d want 555", bus.m_r1c1); end
    meas_run(0, 1, -1, 1, 5, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (ss !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", ss); end
    checks++; if (dc !== 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL sat_abort got done=%0d busy=%b want 0 0", dc, bus.busy); end
  endtask

  task automatic test_abort();
    int da, dc, ea, ec; logic sb, ss; logic [15:0] sx0, sx1; logic [1:0] sm;
    meas_run(3, 30, -1, 31, 100, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (sb !== 1'b0 || sx0 !== 16'h0 || sx1 !== 16'h0 || sm !== 2'd0) begin errors++; $display("FAIL abort_outputs got busy=%b x0=%h x1=%h mode=%0d want 0 0 0 0", sb, sx0, sx1, sm); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dc); end
    checks++; if (bus.m_r0c0 !== 12'd500 || bus.m_r1c0 !== 12'd600) begin errors++; $display("FAIL abort_col0 got %0d/%0d want 500/600", bus.m_r0c0, bus.m_r1c0); end
    checks++; if (bus.m_r0c1 !== 12'd300 || bus.m_r1c1 !== 12'd555) begin errors++; $display("FAIL abort_col1 got %0d/%0d want 300/555", bus.m_r0c1, bus.m_r1c1); end
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.plant_mode !== 2'd0) begin errors++; $display("FAIL start_abort_idle got busy=%b mode=%0d want 0 0", bus.busy, bus.plant_mode); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_stay got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int da, dc, ea, ec; logic sb, ss; logic [15:0] sx0, sx1; logic [1:0] sm;
    meas_run(0, -1, 10, 11, 55, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (da !== 51 || dc !== 1) begin errors++; $display("FAIL busy_start_timing got done_at=%0d count=%0d want 51 1", da, dc); end
    checks++; if (bus.m_r0c0 !== 12'd100 || bus.m_r1c1 !== 12'd50) begin errors++; $display("FAIL busy_start_result got %0d/%0d want 100/50", bus.m_r0c0, bus.m_r1c1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", bus.busy); end
    meas_run(0, -1, -1, 20, 20, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (sb !== 1'b1 || sx0 !== 16'h7FFF) begin errors++; $display("FAIL rst_pre got busy=%b x0=%h want 1 7fff", sb, sx0); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.x0_out !== 16'sd0 || bus.plant_mode !== 2'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy=%b x0=%h mode=%0d done=%b want 0 0 0 0", bus.busy, bus.x0_out, bus.plant_mode, bus.done); end
    checks++; if ({bus.m_r0c0, bus.m_r1c0, bus.m_r0c1, bus.m_r1c1} !== 48'd0 || bus.sat_flag !== 1'b0) begin errors++; $display("FAIL rst_mid_data got m=%h sat=%b want 0 0", {bus.m_r0c0, bus.m_r1c0, bus.m_r0c1, bus.m_r1c1}, bus.sat_flag); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int da, dc, ea, ec; logic sb, ss; logic [15:0] sx0, sx1; logic [1:0] sm;
`ifdef MEAS_TIMEOUT_EN
    meas_run(4, -1, -1, 275, 300, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (ea !== 274 || ec !== 1) begin errors++; $display("FAIL timeout_pulse got at=%0d count=%0d want 274 1", ea, ec); end
    checks++; if (sb !== 1'b0 || sx0 !== 16'h0 || sm !== 2'd0) begin errors++; $display("FAIL timeout_idle got busy=%b x0=%h mode=%0d want 0 0 0", sb, sx0, sm); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL timeout_no_done got %0d want 0", dc); end
`else
    meas_run(4, 300, -1, 299, 305, da, dc, ea, ec, sb, sx0, sx1, sm, ss);
    checks++; if (sb !== 1'b1 || sx0 !== 16'h7FFF) begin errors++; $display("FAIL wait_busy got busy=%b x0=%h want 1 7fff", sb, sx0); end
    checks++; if (dc !== 0 || ec !== 0) begin errors++; $display("FAIL wait_no_event got done=%0d err=%0d want 0 0", dc, ec); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wait_abort got busy=%b want 0", bus.busy); end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_ch0 = 12'd0;
    bus.adc_ch1 = 12'd0;
    #1;
    test_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_avg_toggle();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/basis_meas_sequencer.md
Name: basis_meas_sequencer

Overview:
Sequences the two-basis column measurement that every calibration iteration needs. It drives x = [1,0], waits for thermal settling, and averages ADC samples on both output channels. It then repeats with x = [0,1] and presents the four averaged matrix-column magnitudes to the calibration FSM. It sits between the calibration FSM (unitary or SVD) and the plant interface, owning the input-vector and plant-mode outputs while a measurement runs.

Parameters:
DATA_WIDTH, 16, input vector width (Q1.15)
ADC_WIDTH, 12, ADC sample width (unsigned)
SETTLE_CYCLES, 16, settle wait after each basis apply; legal range >=1
AVG_SAMPLES, 8, accepted samples averaged per basis; power of two, >=1
TIMEOUT_CYCLES, 256, max cycles without adc_valid in SAMPLE (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a measurement; honoured only in IDLE
abort  in  1  cancel an in-progress measurement
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when all four results are valid
x0_out  out  DATA_WIDTH  input vector element 0 to the plant (Q1.15)
x1_out  out  DATA_WIDTH  input vector element 1 to the plant (Q1.15)
plant_mode  out  2  0 = IDLE, 1 = CAL
adc_valid  in  1  ADC sample strobe
adc_ch0  in  ADC_WIDTH  output channel 0 sample
adc_ch1  in  ADC_WIDTH  output channel 1 sample
m_r0c0, m_r1c0, m_r0c1, m_r1c1  out  ADC_WIDTH each  averaged |y_r| for basis column c
sat_flag  out  1  any accepted sample equal to all-ones during the current or last run
err_timeout  out  1  one-cycle pulse on sample timeout (optional feature only)

Behaviour:
- Reset values: busy=0, done=0, x0_out=x1_out=0, plant_mode=0, all m_*=0, sat_flag=0, err_timeout=0, state IDLE, basis index 0, all counters and accumulators 0.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: on start and not abort, go to APPLY. Clear sat_flag, basis index 0, and both accumulators.
- APPLY (1 cycle):
  - basis 0: x0_out=0x7FFF, x1_out=0x0000.
  - basis 1: x0_out=0x0000, x1_out=0x7FFF.
  - plant_mode=1.
  - Registered outputs become visible on the first APPLY cycle. They hold through SETTLE and SAMPLE.
- SETTLE: counts exactly SETTLE_CYCLES cycles. adc_valid is ignored.
- SAMPLE:
  - On each adc_valid, add adc_ch0 and adc_ch1 into accumulators of width ADC_WIDTH+log2(AVG_SAMPLES). No overflow is possible.
  - Any accepted sample equal to 2^ADC_WIDTH-1 sets sat_flag, which is sticky until the next start.
  - On the AVG_SAMPLES-th accepted sample, the same cycle's sample is included. The result is written as acc >> log2(AVG_SAMPLES), truncated.
  - basis 0 result → m_r0c0/m_r1c0; basis 1 result → m_r0c1/m_r1c1.
  - Then clear accumulators. If basis 0: set basis 1 and go to APPLY. If basis 1: go to DONE.
- DONE (1 cycle): done=1, x0_out=x1_out=0, plant_mode=0. Next state IDLE.
- Latency with adc_valid held high and start at cycle T: done is high at T + 2·SETTLE_CYCLES + 2·AVG_SAMPLES + 3 (51 cycles at defaults).
- start while busy: ignored.
- start and abort together in IDLE: abort wins, stay in IDLE.
- abort in any non-IDLE state:
  - Next state is IDLE. x outputs go to 0 and plant_mode to 0 on the next cycle.
  - No done pulse. Accumulators are cleared.
  - m_* keep previously completed values, including the basis-0 results already written in this run.
- m_* are stable from done until the next completed write. The consumer samples them on done.
- Async rst mid-run: immediately returns every output to its reset value.

Optional Feature:
MEAS_TIMEOUT_EN
- Defined:
  - In SAMPLE, a counter is cleared on every adc_valid and on SAMPLE entry, and increments otherwise.
  - On reaching TIMEOUT_CYCLES, err_timeout pulses for 1 cycle.
  - The exit path is the same as abort: IDLE, outputs zeroed, no done.
- Undefined: err_timeout is tied 0. SAMPLE waits indefinitely for adc_valid.

Test Plan:
1. Defaults, adc_valid always 1, ch0=100, ch1=200 for basis 0 and ch0=300, ch1=50 for basis 1, start pulse → done 51 cycles after start; m_r0c0=100, m_r1c0=200, m_r0c1=300, m_r1c1=50; sat_flag=0.
2. Basis-0 ch0 samples 0..7 → m_r0c0=3 (28>>3, truncated). adc_valid toggling every other cycle → 8 accepted samples, done arrives correspondingly later.
3. One basis-1 ch1 sample = 0xFFF → sat_flag=1 after done. Next start clears it to 0 on the following cycle.
4. abort during basis-1 SETTLE → next cycle busy=0, x0_out=x1_out=0, plant_mode=0, no done. m_r*c0 hold the new basis-0 values; m_r*c1 hold the previous run's values. start in the same cycle as abort in IDLE → remains idle.
5. start pulse while busy → ignored, timing unchanged. Assert rst mid-SAMPLE → all outputs 0 immediately.
6. MEAS_TIMEOUT_EN defined, TIMEOUT_CYCLES=256, adc_valid held 0 in SAMPLE → err_timeout pulse 256 cycles after SAMPLE entry, then IDLE with no done. Undefined → busy stays 1.
